// File: rtl/ski_pkg.sv
// Shared constants, action field layout and FSM state type for the SKI heap memory stage.
package ski_pkg;

  localparam int PTR_W  = 30;
  localparam int NODE_W = 63;
  localparam int RESP_W = 65;
  localparam int ACT_W  = 95;

  localparam int ACT_TAG_HI  = 94;
  localparam int ACT_TAG_LO  = 93;
  localparam int ACT_PTR_HI  = 92;
  localparam int ACT_PTR_LO  = 63;
  localparam int ACT_DATA_HI = 62;
  localparam int ACT_DATA_LO = 0;

  localparam logic [1:0] TAG_READ  = 2'b00;
  localparam logic [1:0] TAG_WRITE = 2'b01;
  localparam logic [1:0] TAG_NONE  = 2'b10;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } heap_state_e;

endpackage

// File: rtl/ski_heap_ram.sv
// Synchronous single-port read-first RAM holding the SKI node heap.
module ski_heap_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 63
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Read returns the word as it was before this cycle's write.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ski_heap_mem.sv
// Heap memory stage: clears the node heap after reset, serves READ/WRITE actions, traps bad pointers.
// Optional access counters are built when SKI_HEAP_STATS_EN is defined.
module ski_heap_mem
  import ski_pkg::*;
#(
  parameter int                ADDR_W  = 12,
  parameter logic [NODE_W-1:0] CLR_VAL = 63'd0
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic [ACT_W-1:0]  act_i,
  input  logic              act_en_i,
  output logic              ready_o,
  output logic [RESP_W-1:0] resp_o,
  output logic              fault_o,
  output logic              clr_done_o
`ifdef SKI_HEAP_STATS_EN
  ,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  heap_state_e       state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [ADDR_W-1:0] clr_addr_d;
  logic              ready_q;
  logic              fault_q;
  logic              clr_done_q;
  logic              resp_vld_q;
  logic              resp_flt_q;
  logic              resp_sel_rd_q;
  logic [NODE_W-1:0] resp_data_q;

  logic [1:0]        tag_s;
  logic [PTR_W-1:0]  ptr_s;
  logic [NODE_W-1:0] data_s;
  logic              oor_s;
  logic              accept_s;
  logic              rd_ok_s;
  logic              wr_ok_s;
  logic              bad_s;
  logic              clr_last_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [NODE_W-1:0] ram_wdata_s;
  logic [NODE_W-1:0] ram_rdata_s;

  assign tag_s      = act_i[ACT_TAG_HI:ACT_TAG_LO];
  assign ptr_s      = act_i[ACT_PTR_HI:ACT_PTR_LO];
  assign data_s     = act_i[ACT_DATA_HI:ACT_DATA_LO];
  // Range check on the full pointer, before truncation to the RAM address.
  assign oor_s      = (ptr_s >> ADDR_W) != {PTR_W{1'b0}};
  assign accept_s   = act_en_i & ready_q;
  assign clr_addr_d = clr_addr_q + ADDR_W'(1);
  assign clr_last_s = (clr_addr_q == ADDR_W'(DEPTH - 1));

  // Classify the accepted action.
  always_comb begin
    rd_ok_s = 1'b0;
    wr_ok_s = 1'b0;
    bad_s   = 1'b0;
    if (accept_s) begin
      case (tag_s)
        TAG_READ: begin
          rd_ok_s = ~oor_s;
          bad_s   = oor_s;
        end
        TAG_WRITE: begin
          wr_ok_s = ~oor_s;
          bad_s   = oor_s;
        end
        TAG_NONE: begin
          bad_s = 1'b0;
        end
        default: begin
          bad_s = 1'b1;
        end
      endcase
    end else begin
      bad_s = 1'b0;
    end
  end

  // RAM port is owned by the clear sweep in CLEAR and by accepted actions otherwise.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_addr_s  = ptr_s[ADDR_W-1:0];
    ram_wdata_s = data_s;
    if (system1000_rst) begin
      ram_we_s = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      ram_we_s    = 1'b1;
      ram_addr_s  = clr_addr_q;
      ram_wdata_s = CLR_VAL;
    end else begin
      ram_we_s = wr_ok_s;
    end
  end

  ski_heap_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (NODE_W)
  ) u_ram (
    .clk_i   (system1000),
    .we_i    (ram_we_s),
    .addr_i  (ram_addr_s),
    .wdata_i (ram_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  // Control FSM with registered status and response fields.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q       <= ST_CLEAR;
      clr_addr_q    <= {ADDR_W{1'b0}};
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
      clr_done_q    <= 1'b0;
      resp_vld_q    <= 1'b0;
      resp_flt_q    <= 1'b0;
      resp_sel_rd_q <= 1'b0;
      resp_data_q   <= {NODE_W{1'b0}};
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_addr_q    <= clr_addr_d;
          clr_done_q    <= clr_last_s;
          ready_q       <= 1'b0;
          resp_vld_q    <= 1'b0;
          resp_flt_q    <= 1'b0;
          resp_sel_rd_q <= 1'b0;
          resp_data_q   <= {NODE_W{1'b0}};
          if (clr_last_s) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          clr_done_q    <= 1'b0;
          ready_q       <= ~bad_s;
          resp_vld_q    <= rd_ok_s | wr_ok_s | bad_s;
          resp_flt_q    <= bad_s;
          resp_sel_rd_q <= rd_ok_s;
          resp_data_q   <= wr_ok_s ? data_s : {NODE_W{1'b0}};
          if (bad_s) begin
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end
        end
        ST_FAULT: begin
          clr_done_q    <= 1'b0;
          ready_q       <= 1'b0;
          resp_vld_q    <= 1'b0;
          resp_flt_q    <= 1'b0;
          resp_sel_rd_q <= 1'b0;
          resp_data_q   <= {NODE_W{1'b0}};
        end
        default: begin
          state_q    <= ST_FAULT;
          fault_q    <= 1'b1;
          ready_q    <= 1'b0;
          clr_done_q <= 1'b0;
          resp_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign fault_o    = fault_q;
  assign clr_done_o = clr_done_q;
  // Read data comes straight from the RAM output register to keep latency at one cycle.
  assign resp_o     = {resp_vld_q, resp_flt_q, resp_sel_rd_q ? ram_rdata_s : resp_data_q};

`ifdef SKI_HEAP_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  // Count accepted in-range accesses; wraps naturally.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_q + {31'd0, rd_ok_s};
      wr_cnt_q <= wr_cnt_q + {31'd0, wr_ok_s};
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
